// File: rtl/hangman_msg_rx.sv
// hangman_msg_rx: 8N1 serial receiver for the host/player radio link.
// It deserializes one character per frame, checks the stop bit and holds the
// byte in a single-entry buffer until the game logic acknowledges it.
module hangman_msg_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_serial,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CntLast = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CntHalf = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BitLast = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    DONE
  } state_t;

  state_t                 state_q, state_d;
  logic                   sync1_q, sync2_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BW-1:0]          bitIdx_q, bitIdx_d;
  logic [DATA_BITS-1:0]   shiftReg_q, shiftReg_d;
  logic                   armed_q, armed_d;
  logic                   frameErr_q, frameErr_d;
  logic [DATA_BITS-1:0]   rxData_q;
  logic                   rxValid_q;
  logic                   overrun_q;

  // Two-flop synchronizer; both flops preset to the idle-high line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_serial;
      sync2_q <= sync1_q;
    end
  end

  // Frame state machine registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bitIdx_q   <= '0;
      shiftReg_q <= '0;
      armed_q    <= 1'b0;
      frameErr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bitIdx_q   <= bitIdx_d;
      shiftReg_q <= shiftReg_d;
      armed_q    <= armed_d;
      frameErr_q <= frameErr_d;
    end
  end

  // Next-state logic: mid-bit sampling, and IDLE only arms after the line has
  // been seen high so a held-low break cannot retrigger endlessly.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bitIdx_d   = bitIdx_q;
    shiftReg_d = shiftReg_q;
    armed_d    = armed_q;
    frameErr_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (sync2_q) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          armed_d = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == CntHalf) begin
          cnt_d    = '0;
          bitIdx_d = '0;
          state_d  = sync2_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == CntLast) begin
          cnt_d                = '0;
          shiftReg_d[bitIdx_q] = sync2_q;
          if (bitIdx_q == BitLast) begin
            state_d = STOP;
          end else begin
            bitIdx_d = bitIdx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == CntLast) begin
          cnt_d = '0;
          if (sync2_q) begin
            armed_d = 1'b1;
            state_d = DONE;
          end else begin
            armed_d    = 1'b0;
            frameErr_d = 1'b1;
            state_d    = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Holding buffer: a DONE write beats a same-cycle ack; a full buffer flags overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxData_q  <= '0;
      rxValid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else if (state_q == DONE) begin
      if (!rxValid_q || rx_ack) begin
        rxData_q  <= shiftReg_q;
        rxValid_q <= 1'b1;
      end else begin
        overrun_q <= 1'b1;
      end
    end else if (rx_ack) begin
      rxValid_q <= 1'b0;
    end
  end

  assign rx_data   = rxData_q;
  assign rx_valid  = rxValid_q;
  assign frame_err = frameErr_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_hangman_msg_rx.sv
// Scoreboard bench for hangman_msg_rx: stimulus pushes expected bytes or
// framing-error events; a negedge monitor pops and compares them.
module tb_hangman_msg_rx;

  localparam int CPB = 16;
  localparam int ERR_EVENT = 256;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxSerial;
  logic       rxAck;
  logic [7:0] rxData;
  logic       rxValid;
  logic       frameErr;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int lastWriteCycle = -1;
  int expQ[$];

  logic       prevValid = 1'b0;
  logic       prevErr = 1'b0;
  logic [7:0] prevData = 8'h00;

  hangman_msg_rx #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_serial(rxSerial),
    .rx_ack(rxAck),
    .rx_data(rxData),
    .rx_valid(rxValid),
    .frame_err(frameErr),
    .overrun(overrun),
    .busy(busy)
  );

  // Free-running clock and a cycle counter used for latency measurement.
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Compare one value and report any difference.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Advance n cycles, leaving inputs stable just after each rising edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one 8N1 frame; optionally pulse ack or assert reset at a frame cycle.
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit,
                               input int ackAt, input int rstAt);
    logic [9:0] frame;
    frame = {stopBit, data, 1'b0};
    for (int c = 0; c < 10 * CPB; c++) begin
      rxSerial = frame[c / CPB];
      rxAck = (c == ackAt);
      if (c == rstAt) rst = 1'b1;
      @(posedge clk);
      #1;
      if (rstAt >= 0 && c == rstAt + 2) begin
        rst = 1'b0;
        rxSerial = 1'b1;
        break;
      end
    end
    rxAck = 1'b0;
    rxSerial = 1'b1;
  endtask

  // Monitor: every buffer write and every frame_err pulse must match the
  // head of the expectation queue; frame_err must never last two cycles.
  always @(negedge clk) begin
    if (rst) begin
      prevValid <= 1'b0;
      prevErr <= 1'b0;
      prevData <= 8'h00;
    end else begin
      if (frameErr) begin
        checkOutput("frame_err single cycle", {31'd0, prevErr}, 32'd0);
        if (expQ.size() == 0) begin
          checkOutput("unexpected frame_err", ERR_EVENT, 32'hFFFF_FFFF);
        end else begin
          checkOutput("frame_err event", ERR_EVENT, expQ.pop_front());
        end
      end
      if (rxValid && (!prevValid || rxData != prevData)) begin
        lastWriteCycle = cycle;
        if (expQ.size() == 0) begin
          checkOutput("unexpected rx write", {24'd0, rxData}, 32'hFFFF_FFFF);
        end else begin
          checkOutput("rx_data write", {24'd0, rxData}, expQ.pop_front());
        end
      end
      prevValid <= rxValid;
      prevErr <= frameErr;
      prevData <= rxData;
    end
  end

  // Safety net so the bench can never hang.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    int startCycle;
    int lat;
    rst = 1'b1;
    rxSerial = 1'b1;
    rxAck = 1'b0;
    idle(3);
    checkOutput("reset rx_data", {24'd0, rxData}, 32'h0);
    checkOutput("reset rx_valid", {31'd0, rxValid}, 32'h0);
    checkOutput("reset frame_err", {31'd0, frameErr}, 32'h0);
    checkOutput("reset overrun", {31'd0, overrun}, 32'h0);
    checkOutput("reset busy", {31'd0, busy}, 32'h0);
    rst = 1'b0;
    idle(4);

    // Single frame 'A' with latency and ack.
    expQ.push_back(8'h41);
    startCycle = cycle;
    applyStimulus(8'h41, 1'b1, -1, -1);
    lat = lastWriteCycle - startCycle;
    $display("[TB] latency of 'A' = %0d cycles", lat);
    checkOutput("latency 155+-1", {31'd0, (lat >= 154 && lat <= 156)}, 32'd1);
    checkOutput("A rx_valid", {31'd0, rxValid}, 32'd1);
    checkOutput("A frame_err", {31'd0, frameErr}, 32'd0);
    rxAck = 1'b1;
    idle(1);
    rxAck = 1'b0;
    checkOutput("A ack clears rx_valid", {31'd0, rxValid}, 32'd0);
    idle(4);

    // Start-bit glitch of 5 cycles.
    rxSerial = 1'b0;
    idle(5);
    checkOutput("glitch busy", {31'd0, busy}, 32'd1);
    rxSerial = 1'b1;
    idle(10);
    checkOutput("glitch busy fall", {31'd0, busy}, 32'd0);
    checkOutput("glitch rx_valid", {31'd0, rxValid}, 32'd0);

    // Framing error on 'P', then a good 'L'.
    expQ.push_back(ERR_EVENT);
    applyStimulus(8'h50, 1'b0, -1, -1);
    checkOutput("P rx_valid", {31'd0, rxValid}, 32'd0);
    idle(4);
    expQ.push_back(8'h4C);
    applyStimulus(8'h4C, 1'b1, -1, -1);
    checkOutput("L rx_valid", {31'd0, rxValid}, 32'd1);
    rxAck = 1'b1;
    idle(1);
    rxAck = 1'b0;
    idle(4);

    // Overrun: 'E' then 'L' without ack.
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(2);
    expQ.push_back(8'h45);
    applyStimulus(8'h45, 1'b1, -1, -1);
    idle(4);
    applyStimulus(8'h4C, 1'b1, -1, -1);
    idle(4);
    checkOutput("overrun rx_data kept", {24'd0, rxData}, 32'h45);
    checkOutput("overrun flag", {31'd0, overrun}, 32'd1);
    checkOutput("overrun rx_valid", {31'd0, rxValid}, 32'd1);

    // Collision: ack lands in the DONE cycle of the second frame.
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    checkOutput("overrun cleared by rst", {31'd0, overrun}, 32'd0);
    idle(2);
    expQ.push_back(8'h45);
    applyStimulus(8'h45, 1'b1, -1, -1);
    idle(4);
    expQ.push_back(8'h4C);
    applyStimulus(8'h4C, 1'b1, 155, -1);
    idle(2);
    checkOutput("collision rx_data", {24'd0, rxData}, 32'h4C);
    checkOutput("collision rx_valid", {31'd0, rxValid}, 32'd1);
    checkOutput("collision overrun", {31'd0, overrun}, 32'd0);
    rxAck = 1'b1;
    idle(1);
    rxAck = 1'b0;
    idle(4);

    // Reset during data bit 4, then a clean 'P'.
    applyStimulus(8'h50, 1'b1, -1, 88);
    checkOutput("midreset rx_data", {24'd0, rxData}, 32'h0);
    checkOutput("midreset rx_valid", {31'd0, rxValid}, 32'd0);
    checkOutput("midreset busy", {31'd0, busy}, 32'd0);
    checkOutput("midreset overrun", {31'd0, overrun}, 32'd0);
    idle(4);
    expQ.push_back(8'h50);
    applyStimulus(8'h50, 1'b1, -1, -1);
    checkOutput("P after reset rx_valid", {31'd0, rxValid}, 32'd1);
    rxAck = 1'b1;
    idle(1);
    rxAck = 1'b0;
    idle(4);

    // Break: line low for 20 bit-times gives exactly one frame_err.
    expQ.push_back(ERR_EVENT);
    rxSerial = 1'b0;
    idle(20 * CPB);
    rxSerial = 1'b1;
    idle(20);
    checkOutput("break rx_valid", {31'd0, rxValid}, 32'd0);
    checkOutput("break busy", {31'd0, busy}, 32'd0);

    checkOutput("scoreboard drained", expQ.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hangman_msg_rx.md
Name: hangman_msg_rx

Overview:
- Serial receiver for the wireless link between host and player boards; it is the receiving end of the message path whose transmit side raises msg_sent.
- Deserializes 8N1 frames (idle high, 1 start bit, 8 data bits LSB first, 1 stop bit) from the radio serial line.
- Validates framing and holds each received character in a one-entry buffer until game logic acknowledges it.
- Feeds guessed or set letters (ASCII) to the game FSM.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal values are 4 or more.
- DATA_BITS, 8, payload bits per frame; fixed at 8 for the letter protocol.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- rx_serial  input  1  asynchronous serial line; idles high
- rx_ack  input  1  consumer pulse; frees the holding buffer
- rx_data  output  8  held received byte
- rx_valid  output  1  high while the buffer holds an unread byte
- frame_err  output  1  one-cycle pulse when a stop bit is sampled low
- overrun  output  1  sticky; set when a frame completes while rx_valid=1; cleared by rst only
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset: rst sampled high at a clk edge drives all state to reset values.
  - Outputs: rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0.
  - FSM goes to IDLE; counters clear; both synchronizer flops preset to 1.
  - Reset mid-frame aborts the frame; no partial byte is ever written.
- Input: rx_serial passes through a 2-flop synchronizer (sync2). All decisions use sync2 only.
- Bit-cycle counter cnt: 0..CLKS_PER_BIT-1. Bit index bidx: 0..7.
- FSM states and transitions:
  - IDLE: on sync2==0, go to START with cnt=0.
  - START: wait until cnt==CLKS_PER_BIT/2-1 (mid start bit).
    - If sync2 is still 0: go to DATA, cnt=0, bidx=0.
    - Otherwise it is a glitch: return to IDLE with no output.
  - DATA: at cnt==CLKS_PER_BIT-1, shift sync2 into shreg[bidx] (LSB first) and reset cnt.
    - When bidx==7, go to STOP; otherwise increment bidx.
  - STOP: at cnt==CLKS_PER_BIT-1, sample the stop bit.
    - Stop bit 1: go to DONE.
    - Stop bit 0: pulse frame_err for one cycle, discard the byte, go to IDLE.
  - DONE (one cycle), then IDLE:
    - Buffer empty (rx_valid=0, or rx_ack this cycle): rx_data<=shreg, rx_valid<=1.
    - Buffer full with no rx_ack: set overrun and discard the new byte; the old rx_data is kept.
- Samples land at mid-bit. Odd CLKS_PER_BIT uses floor for the half-bit.
- Latency:
  - Start-bit falling edge at the pin to rx_valid rising: 2 (sync) + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles.
  - With CLKS_PER_BIT=16 that is 155 cycles, ±1 depending on edge alignment.
- rx_ack handling:
  - rx_ack with rx_valid=1 clears rx_valid on the next edge.
  - rx_ack with rx_valid=0 is ignored.
  - rx_ack and a DONE write in the same cycle: the write wins, so rx_valid stays 1 with the new data and no overrun.
- rx_data changes only on a buffer write.
- Back-to-back frames: the FSM returns to IDLE in time to catch a start bit that begins right after the stop bit.
- Line held low (break):
  - Start is confirmed, 8 zero bits are read, and frame_err pulses.
  - The FSM then stays in IDLE until the line rises and falls again.
  - Required mechanism: IDLE only arms after sync2 has been seen high for at least one cycle.

Test Plan:
- Reset: hold rst for 3 cycles with the line idle -> all outputs 0; busy=0.
- Single frame: with CLKS_PER_BIT=16, send 0x41 ('A') -> rx_valid rises 155±1 cycles after the falling edge, rx_data=0x41, frame_err=0, then pulse rx_ack -> rx_valid=0 next cycle.
- Glitch: drive rx_serial low for 5 cycles, then high -> FSM returns to IDLE, busy falls within 8+2 cycles, rx_valid stays 0.
- Framing error: send 0x50 ('P') with stop bit 0 -> frame_err is high for exactly one cycle, rx_valid=0; a following valid 0x4C ('L') is received correctly.
- Overrun and collision:
  - Send 0x45 then 0x4C without rx_ack -> rx_data stays 0x45, overrun=1.
  - After rst, send two frames and assert rx_ack exactly in the DONE cycle of the second -> rx_data=0x4C, rx_valid=1, overrun=0.
- Reset mid-frame and break: assert rst during DATA bit 4 -> outputs return to reset values and the next frame 0x50 is received intact. Hold the line low for 20 bit-times -> one frame_err pulse, no rx_valid.
